// File: rtl/tqvp_pwm_multi.sv
// tqvp_pwm_multi -- multi-channel PWM peripheral for the TinyQV peripheral bus.
//
// NCH channels share one prescaler and one 8-bit period counter. Each channel
// has a double-buffered duty register and an output polarity bit. New duty and
// period values move from shadow to active copies only at a period boundary
// (wrap), on FORCE_UPD, or continuously while the block is disabled.
//
// Optional feature: define PWM_CENTER_EN to build center-aligned (up/down)
// counting selected by CTRL.b1. Without it CTRL.b1 reads 0, only edge mode
// exists and no direction flop is built.
//
// Ports:
//   clk         clock
//   rst_n       synchronous, active-low reset
//   ui_in       unused
//   uo_out      uo_out[i] = chan_out[i % NCH]
//   address     register address (0x0-0x7 DUTYn, 0x8 PERIOD, 0x9/0xA PRESCALE,
//               0xB CTRL, 0xC POL, 0xD STAT, 0xE CNT)
//   data_write  write strobe
//   data_in     write data
//   data_out    read data, combinational from address
module tqvp_pwm_multi #(
  parameter int NCH        = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0]            duty_sh_reg  [NCH];
  logic [7:0]            duty_act_reg [NCH];
  logic [7:0]            top_sh_reg, top_act_reg;
  logic [7:0]            pre_lo_reg, pre_hi_reg;
  logic                  en_reg;
  logic [NCH-1:0]        pol_reg;
  logic                  upd_pend_reg, wrap_flag_reg;
  logic [PRESCALE_W-1:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [NCH-1:0]        chan_out_reg;
  logic [NCH-1:0]        wr_duty;
  logic                  center_rd;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in};

  // Write decodes
  logic wr_top, wr_lo, wr_hi, wr_ctrl, wr_pol, wr_stat, force_upd;
  assign wr_top    = data_write && (address == 4'h8);
  assign wr_lo     = data_write && (address == 4'h9);
  assign wr_hi     = data_write && (address == 4'hA);
  assign wr_ctrl   = data_write && (address == 4'hB);
  assign wr_pol    = data_write && (address == 4'hC);
  assign wr_stat   = data_write && (address == 4'hD);
  assign force_upd = wr_ctrl && data_in[2];

  logic [15:0]           prescale_full;
  logic [PRESCALE_W-1:0] prescale;
  assign prescale_full = {pre_hi_reg, pre_lo_reg};
  assign prescale      = prescale_full[PRESCALE_W-1:0];

  // The counter runs only while enabled; a CTRL write that clears EN or
  // requests FORCE_UPD resets the counter on that same edge.
  logic counting, tick, wrap_cond, wrap, load_act;
  assign counting = en_reg && !(wr_ctrl && (!data_in[0] || data_in[2]));
  assign tick     = (pre_cnt_reg == prescale);
  assign wrap     = counting && tick && wrap_cond;
  // Actives follow shadows every cycle while disabled.
  assign load_act = !en_reg || force_upd || wrap;

`ifdef PWM_CENTER_EN
  logic center_reg;
  logic dir_reg, dir_next;   // 0 = counting up, 1 = counting down
  logic center_chg;
  assign center_rd  = center_reg;
  assign center_chg = wr_ctrl && (data_in[1] != center_reg);
  // In center mode CNT returns to 0 only at a period start.
  assign wrap_cond  = center_reg ? (cnt_reg == 8'd0) : (cnt_reg == top_act_reg);
`else
  assign center_rd  = 1'b0;
  assign wrap_cond  = (cnt_reg == top_act_reg);
`endif

  always_comb begin
    pre_cnt_next = pre_cnt_reg;
    cnt_next     = cnt_reg;
`ifdef PWM_CENTER_EN
    dir_next     = dir_reg;
`endif
    if (!counting) begin
      pre_cnt_next = '0;
      cnt_next     = 8'd0;
`ifdef PWM_CENTER_EN
      dir_next     = 1'b0;
`endif
    end else begin
      pre_cnt_next = tick ? '0 : pre_cnt_reg + PRESCALE_W'(1);
      if (tick) begin
`ifdef PWM_CENTER_EN
        if (center_reg) begin
          if (top_act_reg == 8'd0) begin
            cnt_next = 8'd0;
            dir_next = 1'b0;
          end else if (!dir_reg) begin
            if (cnt_reg >= top_act_reg) begin
              dir_next = 1'b1;
              cnt_next = cnt_reg - 8'd1;
            end else begin
              cnt_next = cnt_reg + 8'd1;
            end
          end else if (cnt_reg == 8'd0) begin
            dir_next = 1'b0;
            cnt_next = 8'd1;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end else begin
          cnt_next = (cnt_reg == top_act_reg) ? 8'd0 : cnt_reg + 8'd1;
        end
`else
        cnt_next = (cnt_reg == top_act_reg) ? 8'd0 : cnt_reg + 8'd1;
`endif
      end
`ifdef PWM_CENTER_EN
      if (center_chg) dir_next = 1'b0;
`endif
    end
  end

  // Shared control and status state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_sh_reg    <= 8'd0;
      top_act_reg   <= 8'd0;
      pre_lo_reg    <= 8'd0;
      pre_hi_reg    <= 8'd0;
      en_reg        <= 1'b0;
      pol_reg       <= '0;
      upd_pend_reg  <= 1'b0;
      wrap_flag_reg <= 1'b0;
      pre_cnt_reg   <= '0;
      cnt_reg       <= 8'd0;
    end else begin
      if (wr_top)  top_sh_reg <= data_in;
      if (wr_lo)   pre_lo_reg <= data_in;
      if (wr_hi)   pre_hi_reg <= data_in;
      if (wr_ctrl) en_reg     <= data_in[0];
      if (wr_pol)  pol_reg    <= data_in[NCH-1:0];
      if (load_act) top_act_reg <= top_sh_reg;
      // A shadow write in the same cycle as a wrap keeps the update pending.
      if (!en_reg || force_upd)        upd_pend_reg <= 1'b0;
      else if (wr_top || (|wr_duty))   upd_pend_reg <= 1'b1;
      else if (wrap)                   upd_pend_reg <= 1'b0;
      // A simultaneous wrap beats the write-1-to-clear.
      if (wrap)                        wrap_flag_reg <= 1'b1;
      else if (wr_stat && data_in[1])  wrap_flag_reg <= 1'b0;
      pre_cnt_reg <= pre_cnt_next;
      cnt_reg     <= cnt_next;
    end
  end

`ifdef PWM_CENTER_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      center_reg <= 1'b0;
      dir_reg    <= 1'b0;
    end else begin
      if (wr_ctrl) center_reg <= data_in[1];
      dir_reg <= dir_next;
    end
  end
`endif

  // Per-channel duty buffers and output flops
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr_duty[gi] = data_write && (address == 4'(gi));
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          duty_sh_reg[gi]  <= 8'd0;
          duty_act_reg[gi] <= 8'd0;
          chan_out_reg[gi] <= 1'b0;
        end else begin
          if (wr_duty[gi]) duty_sh_reg[gi]  <= data_in;
          if (load_act)    duty_act_reg[gi] <= duty_sh_reg[gi];
          // Disabled channels rest at their polarity level.
          chan_out_reg[gi] <= (en_reg && (cnt_reg < duty_act_reg[gi])) ^ pol_reg[gi];
        end
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_out
      assign uo_out[gi] = chan_out_reg[gi % NCH];
    end
  endgenerate

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h8: data_out = top_sh_reg;
      4'h9: data_out = pre_lo_reg;
      4'hA: data_out = pre_hi_reg;
      4'hB: data_out = {6'd0, center_rd, en_reg};
      4'hC: data_out = 8'(pol_reg);
      4'hD: data_out = {6'd0, wrap_flag_reg, upd_pend_reg};
      4'hE: data_out = cnt_reg;
      4'hF: data_out = 8'h00;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (address == 4'(i)) data_out = duty_sh_reg[i];
        end
      end
    endcase
  end

endmodule
